// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and sampler FSM states.
// Used by the uniform/eta rejection samplers and the NTT blocks.
package dilithium_pkg;

    localparam int DIL_Q      = 8380417;
    localparam int DIL_N      = 256;
    localparam int DIL_COEF_W = 23;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } samp_state_e;

endpackage

// File: rtl/rej_byte_buf.sv
// Little-endian byte FIFO between the 64-bit sponge words and 3-byte candidates.
// Holds up to 10 bytes; a pop and a push may happen in the same cycle.
module rej_byte_buf #(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [WORD_W-1:0] push_word,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic              pop3,
    output logic [23:0]       out,
    output logic [3:0]        cnt
);

    localparam int BUF_W = WORD_W + 16;

    logic [BUF_W-1:0] byte_q;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] appended;
    logic [3:0]       cnt_s;
    logic             push;

    always_comb begin
        cnt_s      = pop3 ? cnt - 4'd3 : cnt;
        shifted    = pop3 ? (byte_q >> 24) : byte_q;
        push_ready = en && (cnt_s <= 4'd2);
        push       = push_valid && push_ready;
        // Bytes above cnt_s are always zero, so the OR places the word cleanly.
        appended   = shifted | ({16'b0, push_word} << {cnt_s, 3'b000});
    end

    assign out = byte_q[23:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_q <= '0;
            cnt    <= '0;
        end else begin
            byte_q <= push ? appended : shifted;
            cnt    <= push ? cnt_s + 4'd8 : cnt_s;
        end
    end

endmodule

// File: rtl/rej_uniform_sampler.sv
// Dilithium ExpandA rejection sampler: 3-byte candidates masked to 23 bits,
// kept when below q, streamed out as N indexed coefficients per polynomial.
module rej_uniform_sampler
    import dilithium_pkg::*;
#(
    parameter int DATA_IN_BITS = 64,
    parameter int Q            = DIL_Q,
    parameter int N            = DIL_N,
    parameter int COEF_W       = DIL_COEF_W,
    parameter int IDX_W        = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_IN_BITS-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [COEF_W-1:0]       coef_data,
    output logic [IDX_W-1:0]        coef_idx,
    output logic                    coef_valid,
    output logic                    coef_last,
    input  logic                    coef_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [COEF_W-1:0] Q_V    = COEF_W'(Q);
    localparam logic [IDX_W:0]    N_V    = (IDX_W + 1)'(N);
    localparam logic [IDX_W:0]    LAST_V = (IDX_W + 1)'(N - 1);

    samp_state_e state, state_n;

    logic [IDX_W:0]      idx;
    logic [23:0]         win;
    logic [3:0]          cnt;
    logic [COEF_W-1:0]   cand;
    logic                run_en;
    logic                free;
    logic                pop3;
    logic                accept;
    logic                clear;

    always_comb begin
        run_en = (state == RUN) && (idx < N_V);
        free   = !coef_valid || coef_ready;
        pop3   = run_en && (cnt >= 4'd3) && free;
        // Top bit of the third byte is dropped before the bound check.
        cand   = {win[22:16], win[15:8], win[7:0]};
        accept = pop3 && (cand < Q_V);
        clear  = ((state == IDLE) && start) || (state == DONE);
    end

    rej_byte_buf #(
        .WORD_W(DATA_IN_BITS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .en        (run_en),
        .push_word (in_data),
        .push_valid(in_valid),
        .push_ready(in_ready),
        .pop3      (pop3),
        .out       (win),
        .cnt       (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (coef_valid && coef_ready && coef_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            coef_data  <= '0;
            coef_idx   <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
            if (accept) begin
                coef_data  <= cand;
                coef_idx   <= idx[IDX_W-1:0];
                coef_last  <= (idx == LAST_V);
                coef_valid <= 1'b1;
            end else if (coef_ready) begin
                coef_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed bench for rej_uniform_sampler with a byte-stream rejection model.
// Checks are immediate assertions counted into checks/errors.
module tb_rej_uniform_sampler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] coef_data;
    logic [7:0]  coef_idx;
    logic        coef_valid;
    logic        coef_last;
    logic        coef_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [63:0] words[$];
    int          wpos;
    logic [22:0] got_data[$];
    int          got_idx[$];
    bit          got_last[$];
    logic [22:0] exp_q[$];
    int          done_cnt;

    rej_uniform_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_data (coef_data),
        .coef_idx  (coef_idx),
        .coef_valid(coef_valid),
        .coef_last (coef_last),
        .coef_ready(coef_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Golden RejNTTPoly over the little-endian byte stream of words[].
    function automatic void build_model();
        logic [7:0]  b[$];
        logic [63:0] w;
        logic [22:0] c;
        exp_q.delete();
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 8; k++) b.push_back(w[8*k +: 8]);
        end
        for (int i = 0; i + 2 < b.size() && exp_q.size() < 256; i += 3) begin
            c = {b[i+2][6:0], b[i+1], b[i]};
            if (c < 23'd8380417) exp_q.push_back(c);
        end
    endfunction

    function automatic void clear_got();
        got_data.delete();
        got_idx.delete();
        got_last.delete();
        done_cnt = 0;
        wpos     = 0;
    endfunction

    // rmode: 0 ready always high, 1 random, 2 ready held low.
    task automatic run(input int max_cyc, input bit rand_v, input int rmode,
                       input int stop_hs, input bit stop_done,
                       input bit rand_start);
        int n = 0;
        while (n < max_cyc) begin
            if (stop_done && done_cnt > 0) break;
            if (stop_hs > 0 && got_data.size() >= stop_hs) break;
            in_valid = (wpos < words.size()) &&
                       (!rand_v || $urandom_range(0, 3) != 0);
            in_data  = (wpos < words.size()) ? words[wpos] : 64'd0;
            coef_ready = (rmode == 0) ? 1'b1 :
                         (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            start = rand_start && ($urandom_range(0, 15) == 0);
            #1;
            if (in_valid && in_ready) wpos++;
            if (coef_valid && coef_ready) begin
                got_data.push_back(coef_data);
                got_idx.push_back(int'(coef_idx));
                got_last.push_back(coef_last);
            end
            if (done) done_cnt++;
            tick();
            n++;
        end
        start = 1'b0;
        if (stop_done)
            chk("timeout_done", 32'(done_cnt > 0), 32'd1);
        if (stop_hs > 0)
            chk("timeout_hs", 32'(got_data.size() >= stop_hs), 32'd1);
    endtask

    task automatic compare_all(input string tag, input bit full);
        chk({tag, "_count"}, got_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_q[i]));
            chk({tag, "_idx"}, got_idx[i], i);
            if (full) chk({tag, "_last"}, 32'(got_last[i]), 32'(i == 255));
        end
    endtask

    initial begin
        logic [22:0] held;
        logic [63:0] w;

        // Reset state and IDLE ignoring in_valid
        do_reset();
        chk("rst_valid", coef_valid, 1'b0);
        chk("rst_last", coef_last, 1'b0);
        chk("rst_data", coef_data, 23'd0);
        chk("rst_idx", coef_idx, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'h1;
        #1;
        chk("idle_in_ready", in_ready, 1'b0);
        tick();
        chk("idle_busy", busy, 1'b0);

        // Basic word: coefs 1 then 0, two bytes remain
        in_valid = 1'b0;
        do_start();
        in_valid   = 1'b1;
        in_data    = 64'h0000_0000_0000_0001;
        coef_ready = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_lat_valid", coef_valid, 1'b0);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_c0_valid", coef_valid, 1'b1);
        chk("t1_c0_data", coef_data, 23'd1);
        chk("t1_c0_idx", coef_idx, 8'd0);
        tick();
        chk("t1_c1_data", coef_data, 23'd0);
        chk("t1_c1_idx", coef_idx, 8'd1);
        tick();
        chk("t1_drain_valid", coef_valid, 1'b0);
        chk("t1_rem_in_ready", in_ready, 1'b1);

        // Rejection at q, q-1 accepted, straddling candidate with masked bit
        do_reset();
        do_start();
        in_valid   = 1'b1;
        in_data    = 64'h0005_7FE0_007F_E001;
        coef_ready = 1'b1;
        #1;
        chk("t2_in_ready0", in_ready, 1'b1);
        tick();
        in_data = 64'h0000_0000_0000_0080;
        #1;
        chk("t2_in_ready1", in_ready, 1'b0);
        tick();
        chk("t2_reject_q", coef_valid, 1'b0);
        #1;
        chk("t2_in_ready2", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_qm1_valid", coef_valid, 1'b1);
        chk("t2_qm1_data", coef_data, 23'd8380416);
        chk("t2_qm1_idx", coef_idx, 8'd0);
        tick();
        chk("t2_strad_data", coef_data, 23'd5);
        chk("t2_strad_idx", coef_idx, 8'd1);

        // Backpressure: 20 stalled cycles with in_valid held high
        do_reset();
        words.delete();
        for (int i = 0; i < 6; i++) words.push_back({$urandom, $urandom});
        w = words[0];
        w[23:16] = 8'h00;
        words[0] = w;
        build_model();
        clear_got();
        do_start();
        run(2, 1'b0, 2, 0, 1'b0, 1'b0);
        chk("bp_valid", coef_valid, 1'b1);
        held = coef_data;
        for (int i = 0; i < 20; i++) begin
            run(1, 1'b0, 2, 0, 1'b0, 1'b0);
            chk("bp_hold_valid", coef_valid, 1'b1);
            chk("bp_hold_data", coef_data, held);
            chk("bp_hold_idx", coef_idx, 8'd0);
        end
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_words_taken", wpos, 1);
        run(80, 1'b0, 0, 0, 1'b0, 1'b0);
        compare_all("bp", 1'b0);

        // Full polynomial with random valid/ready gaps
        do_reset();
        words.delete();
        for (int i = 0; i < 130; i++) begin
            w = {$urandom, $urandom};
            if (i % 9 == 4) w = '1;
            words.push_back(w);
        end
        build_model();
        clear_got();
        do_start();
        run(4000, 1'b1, 1, 0, 1'b1, 1'b0);
        run(4, 1'b0, 0, 0, 1'b0, 1'b0);
        compare_all("full", 1'b1);
        chk("full_done_once", done_cnt, 1);
        chk("full_in_ready_after", in_ready, 1'b0);
        chk("full_busy_after", busy, 1'b0);

        // Reset after idx 100, then rerun with stray start pulses
        clear_got();
        do_start();
        run(2000, 1'b1, 1, 101, 1'b0, 1'b0);
        chk("mid_idx100", got_idx[100], 100);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", coef_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_idx", coef_idx, 8'd0);
        rst = 1'b0;
        clear_got();
        do_start();
        run(4000, 1'b1, 1, 0, 1'b1, 1'b1);
        run(4, 1'b0, 0, 0, 1'b0, 1'b0);
        compare_all("restart", 1'b1);
        chk("restart_done_once", done_cnt, 1);
        chk("restart_busy_after", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
